// File: rtl/ppi_bus_master_pkg.sv
// Shared types and constants for the 8255-style bus master.
// Holds FSM encodings, PPI register map and a phase-length helper.
package ppi_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  localparam logic [1:0] PPI_PORT_A = 2'd0;
  localparam logic [1:0] PPI_PORT_B = 2'd1;
  localparam logic [1:0] PPI_PORT_C = 2'd2;
  localparam logic [1:0] PPI_CTRL   = 2'd3;

  // PC/XT control word: A in, B out, C in
  localparam logic [7:0] PPI_CW_XT = 8'h99;

  // Phase length in cycles -> down-counter load value
  function automatic logic [7:0] phase_ld(int unsigned cyc);
    return 8'(cyc - 1);
  endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// Loadable 8-bit down-counter shared by all bus phases.
// Ports: clk_i, rst_ni (sync), load_i, load_val_i[7:0], done_o (count==0).
module ppi_phase_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// Single-transaction bus initiator for 8255-style I/O peripherals.
// Ports: clk, reset_n, req_* (valid/ready request), rsp_* (completion),
// cs_n/rd_n/wr_n/a/d_out/d_oe (registered bus pins), d_in (bus read data).
module ppi_bus_master
  import ppi_bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [1:0] a,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  localparam logic [7:0] SETUP_LD  = phase_ld(SETUP_CYC);
  localparam logic [7:0] STROBE_LD = phase_ld(STROBE_CYC);
  localparam logic [7:0] HOLD_LD   = phase_ld(HOLD_CYC);
  localparam logic [7:0] REC_LD    = phase_ld(RECOVER_CYC);

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic [1:0] a_q, a_d;
  logic [7:0] dout_q, dout_d;
  logic       doe_q, doe_d;
  logic       rv_q, rv_d;
  logic       rw_q, rw_d;
  logic [7:0] rdata_q, rdata_d;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  ppi_phase_timer u_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  // Pin values are computed one edge ahead so every
  // bus output comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    cs_n_d   = cs_n_q;
    rd_n_d   = rd_n_q;
    wr_n_d   = wr_n_q;
    a_d      = a_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    rv_d     = 1'b0;
    rw_d     = rw_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
          wr_d     = req_write;
          a_d      = req_addr;
          dout_d   = req_wdata;
          cs_n_d   = 1'b0;
          doe_d    = req_write;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
          rd_n_d   = wr_q;
          wr_n_d   = ~wr_q;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          rd_n_d   = 1'b1;
          wr_n_d   = 1'b1;
          if (!wr_q) begin
            rdata_d = d_in;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d  = ST_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = REC_LD;
          cs_n_d   = 1'b1;
          doe_d    = 1'b0;
          rv_d     = 1'b1;
          rw_d     = wr_q;
        end
      end
      ST_RECOVER: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a_q     <= PPI_PORT_A;
      dout_q  <= 8'd0;
      doe_q   <= 1'b0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) && reset_n;
  assign rsp_valid = rv_q;
  assign rsp_write = rw_q;
  assign rsp_rdata = rdata_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign a         = a_q;
  assign d_out     = dout_q;
  assign d_oe      = doe_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master with a small 8255 model.
// Default instance plus a slow-timing instance sharing the request side.
module tb_ppi_bus_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;

  logic       rdy1, rv1, rw1, cs_n1, rd_n1, wr_n1, doe1;
  logic [7:0] rdata1, dout1, din1;
  logic [1:0] a1;
  logic       rdy2, rv2, rw2, cs_n2, rd_n2, wr_n2, doe2;
  logic [7:0] rdata2, dout2, din2;
  logic [1:0] a2;

  logic [7:0] pa = 8'hAA;
  logic [7:0] pb = 8'h00;
  logic [7:0] pc = 8'h55;
  logic [7:0] ctrl = 8'h00;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  ppi_bus_master dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_write(rw1), .rsp_rdata(rdata1),
    .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .a(a1),
    .d_out(dout1), .d_oe(doe1), .d_in(din1)
  );

  ppi_bus_master #(
    .SETUP_CYC(2), .STROBE_CYC(4),
    .HOLD_CYC(2), .RECOVER_CYC(3)
  ) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rdy2),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_write(rw2), .rsp_rdata(rdata2),
    .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2), .a(a2),
    .d_out(dout2), .d_oe(doe2), .d_in(din2)
  );

  // 8255 model: drives read data only while selected and strobed
  always_comb begin
    din1 = 8'hFF;
    if (cs_n1 === 1'b0 && rd_n1 === 1'b0) begin
      case (a1)
        2'd0: din1 = pa;
        2'd1: din1 = pb;
        2'd2: din1 = pc;
        default: din1 = ctrl;
      endcase
    end
  end

  always_comb begin
    din2 = 8'hFF;
    if (cs_n2 === 1'b0 && rd_n2 === 1'b0) begin
      case (a2)
        2'd0: din2 = pa;
        2'd1: din2 = pb;
        2'd2: din2 = pc;
        default: din2 = ctrl;
      endcase
    end
  end

  always @(posedge clk) begin
    if (cs_n1 === 1'b0 && wr_n1 === 1'b0 && doe1 === 1'b1) begin
      case (a1)
        2'd1: pb <= dout1;
        2'd3: ctrl <= dout1;
        default: ;
      endcase
    end
  end

  // Bus protocol rules on both instances, every cycle
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      assert (!(rd_n1 === 1'b0 && wr_n1 === 1'b0)
              && !((rd_n1 === 1'b0 || wr_n1 === 1'b0) && cs_n1 !== 1'b0)
              && !(doe1 === 1'b1 && rd_n1 === 1'b0))
      else begin
        errors++;
        $error("FAIL proto1 rd=%b wr=%b cs=%b oe=%b required legal",
               rd_n1, wr_n1, cs_n1, doe1);
      end
      checks++;
      assert (!(rd_n2 === 1'b0 && wr_n2 === 1'b0)
              && !((rd_n2 === 1'b0 || wr_n2 === 1'b0) && cs_n2 !== 1'b0)
              && !(doe2 === 1'b1 && rd_n2 === 1'b0))
      else begin
        errors++;
        $error("FAIL proto2 rd=%b wr=%b cs=%b oe=%b required legal",
               rd_n2, wr_n2, cs_n2, doe2);
      end
    end
  end

  logic       o_rdy, o_rv, o_rw, o_cs, o_rd, o_wr, o_oe;
  logic [7:0] o_rdata, o_dout;

  assign o_rdy   = sel ? rdy2   : rdy1;
  assign o_rv    = sel ? rv2    : rv1;
  assign o_rw    = sel ? rw2    : rw1;
  assign o_cs    = sel ? cs_n2  : cs_n1;
  assign o_rd    = sel ? rd_n2  : rd_n1;
  assign o_wr    = sel ? wr_n2  : wr_n1;
  assign o_oe    = sel ? doe2   : doe1;
  assign o_rdata = sel ? rdata2 : rdata1;
  assign o_dout  = sel ? dout2  : dout1;

  int rd_lo, wr_lo, cs_lo, oe_hi, rv_at, rdy_at;
  logic rv_w;
  logic [7:0] rv_data, oe_dout;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input logic [1:0] ad,
                       input logic [7:0] wd);
    int n = 0;
    while (o_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, o_rdy}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = ad;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Cycle i is the i-th cycle after the accepting edge
  task automatic observe(input int n);
    rd_lo = 0; wr_lo = 0; cs_lo = 0; oe_hi = 0;
    rv_at = 0; rdy_at = 0; rv_w = 1'bx;
    rv_data = 8'hxx; oe_dout = 8'hxx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (o_rd === 1'b0) rd_lo++;
      if (o_wr === 1'b0) wr_lo++;
      if (o_cs === 1'b0) cs_lo++;
      if (o_oe === 1'b1) begin
        oe_hi++;
        oe_dout = o_dout;
      end
      if (o_rv === 1'b1 && rv_at == 0) begin
        rv_at = i;
        rv_w = o_rw;
        rv_data = o_rdata;
      end
      if (o_rdy === 1'b1 && rdy_at == 0) rdy_at = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 2'd0;
    req_wdata = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("rst_cs", {31'd0, cs_n1}, 32'd1);
    chk("rst_rd", {31'd0, rd_n1}, 32'd1);
    chk("rst_wr", {31'd0, wr_n1}, 32'd1);
    chk("rst_a", {30'd0, a1}, 32'd0);
    chk("rst_dout", {24'd0, dout1}, 32'd0);
    chk("rst_oe", {31'd0, doe1}, 32'd0);
    chk("rst_rv", {31'd0, rv1}, 32'd0);
    chk("rst_rw", {31'd0, rw1}, 32'd0);
    chk("rst_rdata", {24'd0, rdata1}, 32'd0);
    chk("rst_ready", {31'd0, rdy1}, 32'd0);
    armed = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy1}, 32'd1);

    // Read port A
    start(1'b0, 2'd0, 8'h00);
    observe(6);
    chk("rdA_rd_lo", rd_lo, 2);
    chk("rdA_cs_lo", cs_lo, 4);
    chk("rdA_wr_lo", wr_lo, 0);
    chk("rdA_oe_hi", oe_hi, 0);
    chk("rdA_rv_at", rv_at, 5);
    chk("rdA_rv_w", {31'd0, rv_w}, 32'd0);
    chk("rdA_data", {24'd0, rv_data}, 32'hAA);
    chk("rdA_rdy_at", rdy_at, 6);

    // Control word then port B write
    start(1'b1, 2'd3, 8'h99);
    observe(6);
    chk("wrC_wr_lo", wr_lo, 2);
    chk("wrC_rv_w", {31'd0, rv_w}, 32'd1);
    chk("wrC_ctrl", {24'd0, ctrl}, 32'h99);
    start(1'b1, 2'd1, 8'h5A);
    observe(6);
    chk("wrB_wr_lo", wr_lo, 2);
    chk("wrB_rd_lo", rd_lo, 0);
    chk("wrB_oe_hi", oe_hi, 4);
    chk("wrB_dout", {24'd0, oe_dout}, 32'h5A);
    chk("wrB_rv_at", rv_at, 5);
    chk("wrB_pb", {24'd0, pb}, 32'h5A);
    chk("wrB_rdata_kept", {24'd0, rdata1}, 32'hAA);

    // Back-to-back reads, request held valid
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 2'd0;
    @(posedge clk);
    #1;
    req_addr = 2'd2;
    req_wdata = 8'h33;
    observe(6);
    chk("b2b1_cs_lo", cs_lo, 4);
    chk("b2b1_rd_lo", rd_lo, 2);
    chk("b2b1_data", {24'd0, rv_data}, 32'hAA);
    chk("b2b1_rdy_at", rdy_at, 6);
    @(posedge clk);
    #1 req_valid = 1'b0;
    observe(6);
    chk("b2b2_rv_at", rv_at, 5);
    chk("b2b2_data", {24'd0, rv_data}, 32'h55);

    // Reset during first strobe cycle
    start(1'b0, 2'd0, 8'h00);
    @(negedge clk);
    chk("mid_setup_cs", {31'd0, cs_n1}, 32'd0);
    @(negedge clk);
    chk("mid_strobe_rd", {31'd0, rd_n1}, 32'd0);
    reset_n = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("mrst_rd", {31'd0, rd_n1}, 32'd1);
    chk("mrst_cs", {31'd0, cs_n1}, 32'd1);
    chk("mrst_oe", {31'd0, doe1}, 32'd0);
    chk("mrst_rv", {31'd0, rv1}, 32'd0);
    chk("mrst_rdata", {24'd0, rdata1}, 32'd0);
    chk("mrst_ready", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("mrst_no_accept", {31'd0, cs_n1}, 32'd1);
    req_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_ready_back", {31'd0, rdy1}, 32'd1);
    chk("mrst_rv_quiet", {31'd0, rv1}, 32'd0);
    start(1'b0, 2'd0, 8'h00);
    observe(6);
    chk("mrst_rd_rv_at", rv_at, 5);
    chk("mrst_rd_data", {24'd0, rv_data}, 32'hAA);

    // Slow-timing instance
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sel = 1'b1;
    start(1'b0, 2'd2, 8'h00);
    observe(12);
    chk("slow_rd_lo", rd_lo, 4);
    chk("slow_cs_lo", cs_lo, 8);
    chk("slow_wr_lo", wr_lo, 0);
    chk("slow_rv_at", rv_at, 9);
    chk("slow_rdy_at", rdy_at, 12);
    chk("slow_data", {24'd0, rv_data}, 32'h55);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
